drum_seq_divider: RTL and testbench
===================================

// Module: drum_seq_divider
// PURPOSE
//   Iterative restoring divider: the inverse of the DRUM multiplier datapath.
//   - Takes a product-width dividend and a multiplier-operand-width divisor.
//   - Returns quotient and remainder, so products can be checked or undone on chip.
//   - Sits beside the multiplier inside the TT user project.
//   - Operands are loaded on a start pulse; a done/busy handshake reports completion.
// PARAMETERS
//   N   4   width of multiplier operand a
//   M   4   width of multiplier operand b; also the divisor width
//   (derived) DW = N+M   dividend and quotient width; not overridable
// PORTS
//   clk        in   1    clock, all state changes on rising edge
//   rst        in   1    synchronous reset, active-high
//   start      in   1    request: sample dividend/divisor this cycle
//   dividend   in   DW   numerator, unsigned
//   divisor    in   M    denominator, unsigned
//   busy       out  1    iteration in progress
//   done       out  1    result valid, held until next accepted start
//   quotient   out  DW   unsigned quotient
//   remainder  out  M    unsigned remainder, always < divisor
//   div_zero   out  1    last accepted request had divisor == 0
// BEHAVIOUR
// - Reset (rst=1 at an edge):
//   - state=IDLE; busy, done and div_zero = 0; quotient and remainder = 0.
//   - Reset mid-RUN aborts the operation; no done pulse follows.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE/DONE, start=1, divisor!=0:
//     - latch operands; partial remainder=0; count=DW-1.
//     - go to RUN; done=0 and busy=1 from the next cycle.
//   - IDLE/DONE, start=1, divisor==0:
//     - go straight to DONE next cycle.
//     - quotient = all ones, remainder = 0, div_zero = 1, busy stays 0.
//   - RUN: one quotient bit per cycle, MSB first.
//     - Shift the next dividend bit into the partial remainder (M+1 bits wide, no overflow).
//     - If partial >= divisor: subtract and set the quotient bit to 1; else 0.
//     - After the iteration where count==0: go to DONE.
//   - DONE: done=1, busy=0, outputs stable until the next accepted start or reset.
//   - start while RUN is ignored; the operands in flight are unaffected.
//   - start in DONE is accepted like IDLE; done drops the cycle after.
// - Latency: start accepted at edge k -> busy high cycles k+1..k+DW, done high from edge k+DW+1.
//   - For DW=8: 9 edges from start to done.
// - quotient/remainder registers update only on entering DONE.
//   - During RUN they keep the previous result.
// - div_zero is updated on every accepted start; cleared for nonzero divisors.
// - busy and done are never both 1. All outputs are registered.
// TESTING (N=M=4)
// 1. Reset, then dividend=6, divisor=2, start for one cycle:
//    - busy for 8 cycles, then done=1, quotient=3, remainder=0, div_zero=0.
// 2. Four cases, each with checks on all outputs and latency:
//    - 200/7 -> q=28, r=4.
//    - 255/15 -> q=17, r=0.
//    - 13/15 -> q=0, r=13.
//    - 255/1 -> q=255, r=0.
// 3. Divide by zero, dividend=9, divisor=0, start:
//    - next cycle done=1, div_zero=1, q=8'hFF, r=0, busy never 1.
// 4. Start 100/3; pulse start with 50/5 at cycle 4 of RUN:
//    - second request ignored; result q=33, r=1 at the normal latency.
// 5. Start 200/7; rst=1 at cycle 3 of RUN:
//    - next cycle busy=0, done=0, q=0, r=0.
//    - fresh 6/2 afterwards yields q=3, r=0.
// 6. Back-to-back: start 6/2 in the cycle after done (DONE state):
//    - done drops next cycle, busy=1.
//    - result q=3 at k+9; the previous result stays visible during RUN.

Source files
------------

// File: rtl/drum_seq_divider_if.sv
// rtl/drum_seq_divider_if.sv - request/result bundle between a divider client and the divider
interface drum_seq_divider_if #(
    parameter int N = 4,
    parameter int M = 4
);
    localparam int DW = N + M;

    logic          start;
    logic [DW-1:0] dividend;
    logic [M-1:0]  divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [M-1:0]  remainder;
    logic          div_zero;

    // Client side: issues requests, observes results
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    // Divider side: accepts requests, produces results
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/drum_seq_divider.sv
// rtl/drum_seq_divider.sv - iterative restoring divider, one quotient bit per cycle
module drum_seq_divider #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic               clk,
    input  logic               rst,
    drum_seq_divider_if.slave  bus
);
    localparam int DW = N + M;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    // Dividend bits still to be consumed sit at the top of work_q; quotient
    // bits enter at the bottom, so after DW shifts it holds the quotient.
    logic [DW-1:0] work_q;
    logic [DW-1:0] work_d;
    // The partial remainder is always < divisor between iterations, so M bits
    // hold it; only the shifted trial value needs the extra bit.
    logic [M-1:0]  part_q;
    logic [M-1:0]  part_d;
    logic [M-1:0]  dsr_q;
    logic [M:0]    shifted;
    logic          take;

    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] quot_q;
    logic [M-1:0]  rem_q;
    logic          dz_q;

    // Trial subtraction for the current iteration. The difference is taken
    // modulo 2^M: when it is kept it is below the divisor, so no bits are lost.
    always_comb begin
        shifted = {part_q, work_q[DW-1]};
        take    = (shifted >= {1'b0, dsr_q});
        part_d  = take ? (shifted[M-1:0] - dsr_q) : shifted[M-1:0];
        work_d  = {work_q[DW-2:0], take};
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            work_q  <= '0;
            part_q  <= '0;
            dsr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            work_q  <= bus.dividend;
                            dsr_q   <= bus.divisor;
                            part_q  <= '0;
                            count_q <= CW'(DW - 1);
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            dz_q    <= 1'b0;
                            state_q <= S_RUN;
                        end else begin
                            // Division by zero resolves immediately with a
                            // saturated quotient; no iteration is started.
                            quot_q  <= '1;
                            rem_q   <= '0;
                            dz_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    // New requests are ignored here; operands in flight stay put.
                    work_q <= work_d;
                    part_q <= part_d;
                    if (count_q == '0) begin
                        quot_q  <= work_d;
                        rem_q   <= part_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_drum_seq_divider.sv
// tb/tb_drum_seq_divider.sv - self-checking bench for drum_seq_divider
module tb_drum_seq_divider;
    localparam int N  = 4;
    localparam int M  = 4;
    localparam int DW = N + M;

    logic clk;
    logic rst;
    int   vec;
    int   miscmp;
    logic [DW-1:0] prev_q;
    logic [M-1:0]  prev_r;

    drum_seq_divider_if #(.N(N), .M(M)) bus ();

    drum_seq_divider #(.N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division; divide-by-zero saturates
    task automatic model_div(input logic [DW-1:0] a, input logic [M-1:0] b,
                             output logic [DW-1:0] q, output logic [M-1:0] r,
                             output logic dz);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            q  = {DW{1'b1}};
            r  = '0;
            dz = 1'b1;
        end else begin
            q  = DW'(ai / bi);
            r  = M'(ai % bi);
            dz = 1'b0;
        end
    endtask

    // Issue one request and follow it to completion; inject_at >= 0 pulses a
    // competing 50/5 request during that busy cycle.
    task automatic divide_op(input string name, input logic [DW-1:0] a,
                             input logic [M-1:0] b, input int inject_at);
        logic [DW-1:0] eq;
        logic [M-1:0]  er;
        logic          edz;
        int            cycles;
        model_div(a, b, eq, er, edz);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (edz) begin
            vec++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.div_zero !== 1'b1) begin
                miscmp++;
                $display("FAIL %s dz_flags: busy=%b done=%b dz=%b, want 0 1 1",
                         name, bus.busy, bus.done, bus.div_zero);
            end
        end else begin
            vec++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                miscmp++;
                $display("FAIL %s accept: busy=%b done=%b, want 1 0", name, bus.busy, bus.done);
            end
            cycles = 0;
            while (bus.busy === 1'b1 && cycles < 40) begin
                vec++;
                if (bus.done !== 1'b0 || bus.quotient !== prev_q || bus.remainder !== prev_r) begin
                    miscmp++;
                    $display("FAIL %s run_hold c%0d: done=%b q=%0d r=%0d, want 0 %0d %0d",
                             name, cycles, bus.done, bus.quotient, bus.remainder, prev_q, prev_r);
                end
                if (cycles == inject_at) begin
                    bus.start    = 1'b1;
                    bus.dividend = 8'd50;
                    bus.divisor  = 4'd5;
                end
                @(posedge clk); #1;
                bus.start = 1'b0;
                cycles++;
            end
            vec++;
            if (cycles != DW) begin
                miscmp++;
                $display("FAIL %s latency: busy cycles=%0d, want %0d", name, cycles, DW);
            end
            vec++;
            if (bus.done !== 1'b1 || bus.div_zero !== 1'b0) begin
                miscmp++;
                $display("FAIL %s done_flags: done=%b dz=%b, want 1 0", name, bus.done, bus.div_zero);
            end
        end
        vec++;
        if (bus.quotient !== eq || bus.remainder !== er) begin
            miscmp++;
            $display("FAIL %s result: q=%0d r=%0d, want q=%0d r=%0d",
                     name, bus.quotient, bus.remainder, eq, er);
        end
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 ||
            bus.quotient !== '0 || bus.remainder !== '0) begin
            miscmp++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b q=%0d r=%0d, want all 0",
                     bus.busy, bus.done, bus.div_zero, bus.quotient, bus.remainder);
        end
        prev_q = '0;
        prev_r = '0;
    endtask

    task automatic test_basic();
        divide_op("basic_6_2", 8'd6, 4'd2, -1);
    endtask

    task automatic test_cases();
        divide_op("c_200_7", 8'd200, 4'd7, -1);
        divide_op("c_255_15", 8'd255, 4'd15, -1);
        divide_op("c_13_15", 8'd13, 4'd15, -1);
        divide_op("c_255_1", 8'd255, 4'd1, -1);
    endtask

    task automatic test_div_zero();
        divide_op("dz_9_0", 8'd9, 4'd0, -1);
        @(posedge clk); #1;
        vec++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 8'hFF) begin
            miscmp++;
            $display("FAIL dz_hold: done=%b busy=%b q=%0d, want 1 0 255",
                     bus.done, bus.busy, bus.quotient);
        end
    endtask

    task automatic test_ignore_start();
        divide_op("ign_100_3", 8'd100, 4'd3, 3);
    endtask

    task automatic test_reset_mid_run();
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0) begin
            miscmp++;
            $display("FAIL rst_mid: busy=%b done=%b q=%0d r=%0d, want 0 0 0 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        end
        prev_q = '0;
        prev_r = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            vec++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscmp++;
                $display("FAIL rst_no_done c%0d: done=%b busy=%b, want 0 0", i, bus.done, bus.busy);
            end
        end
        divide_op("rst_then_6_2", 8'd6, 4'd2, -1);
    endtask

    task automatic test_back_to_back();
        divide_op("b2b_first_77_9", 8'd77, 4'd9, -1);
        divide_op("b2b_6_2", 8'd6, 4'd2, -1);
        divide_op("b2b_dz_after", 8'd5, 4'd0, -1);
        divide_op("b2b_after_dz", 8'd250, 4'd11, -1);
    endtask

    task automatic test_random();
        logic [DW-1:0] a;
        logic [M-1:0]  b;
        for (int i = 0; i < 40; i++) begin
            a = DW'($urandom_range(0, 255));
            b = M'($urandom_range(0, 15));
            divide_op($sformatf("rnd%0d_%0d_%0d", i, a, b), a, b, -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
    endtask

    initial begin
        vec    = 0;
        miscmp = 0;
        test_reset();
        test_basic();
        test_cases();
        test_div_zero();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
